// File: rtl/instruction_mem_arbiter.sv
// Round-robin arbiter that multiplexes per-warp instruction fetch requests onto a
// smaller set of instruction-memory channels, each channel running its own request FSM.
module instruction_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]  consumer_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   mem_read_data
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_WAITING,
        ST_READ_RELAYING
    } state_t;

    state_t                   r_state [NUM_CHANNELS];
    logic [CW-1:0]            r_cons  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] r_claim;
    logic [CW-1:0]            r_rr_ptr;

    logic [NUM_CONSUMERS-1:0] w_eligible;
    logic [NUM_CONSUMERS-1:0] w_taken;
    logic [NUM_CHANNELS-1:0]  w_grant_vld;
    logic [CW-1:0]            w_grant_idx [NUM_CHANNELS];
    logic [CW-1:0]            w_rr_next;
    logic [CW-1:0]            w_cand;

    // Consumer index reached by stepping 'offset' places past 'base', modulo NUM_CONSUMERS.
    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CONSUMERS)
            sum = sum - NUM_CONSUMERS;
        return CW'(sum);
    endfunction

    // A consumer still showing ready is finishing a relay and must not be re-granted yet.
    assign w_eligible = consumer_read_valid & ~r_claim & ~consumer_read_ready;

    // Channels are visited in index order; each takes the next eligible consumer in
    // round-robin order that an earlier channel has not already taken this cycle.
    always_comb begin
        w_taken     = '0;
        w_grant_vld = '0;
        w_rr_next   = r_rr_ptr;
        w_cand      = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_grant_idx[c] = '0;
            if (r_state[c] == ST_IDLE) begin
                for (int o = 0; o < NUM_CONSUMERS; o++) begin
                    w_cand = wrap_idx(r_rr_ptr, o);
                    if (!w_grant_vld[c] && w_eligible[w_cand] && !w_taken[w_cand]) begin
                        w_grant_vld[c]  = 1'b1;
                        w_grant_idx[c]  = w_cand;
                        w_taken[w_cand] = 1'b1;
                        w_rr_next       = wrap_idx(r_rr_ptr, o + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_claim             <= '0;
            r_rr_ptr            <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= ST_IDLE;
                r_cons[c]  <= '0;
            end
        end else begin
            r_rr_ptr <= w_rr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (r_state[c])
                    ST_IDLE: begin
                        if (w_grant_vld[c]) begin
                            r_cons[c]                 <= w_grant_idx[c];
                            r_claim[w_grant_idx[c]]   <= 1'b1;
                            mem_read_valid[c]         <= 1'b1;
                            mem_read_address[c]       <= consumer_read_address[w_grant_idx[c]];
                            r_state[c]                <= ST_READ_WAITING;
                        end
                    end
                    ST_READ_WAITING: begin
                        if (mem_read_ready[c]) begin
                            mem_read_valid[c]                <= 1'b0;
                            mem_read_address[c]              <= '0;
                            consumer_read_ready[r_cons[c]]   <= 1'b1;
                            consumer_read_data[r_cons[c]]    <= mem_read_data[c];
                            r_state[c]                       <= ST_READ_RELAYING;
                        end
                    end
                    ST_READ_RELAYING: begin
                        // The fetcher releases the channel by dropping its valid.
                        if (!consumer_read_valid[r_cons[c]]) begin
                            consumer_read_ready[r_cons[c]] <= 1'b0;
                            consumer_read_data[r_cons[c]]  <= '0;
                            r_claim[r_cons[c]]             <= 1'b0;
                            r_state[c]                     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state[c] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_mem_arbiter.sv
// Directed bench for instruction_mem_arbiter: a 1-channel and a 2-channel instance,
// four consumers each, with memory responses driven step by step.
module tb_instruction_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]        c1_valid;
    logic [3:0][31:0]  c1_addr;
    logic [3:0]        c1_ready;
    logic [3:0][31:0]  c1_data;
    logic [0:0]        m1_valid;
    logic [0:0][31:0]  m1_addr;
    logic [0:0]        m1_ready;
    logic [0:0][31:0]  m1_data;

    logic [3:0]        c2_valid;
    logic [3:0][31:0]  c2_addr;
    logic [3:0]        c2_ready;
    logic [3:0][31:0]  c2_data;
    logic [1:0]        m2_valid;
    logic [1:0][31:0]  m2_addr;
    logic [1:0]        m2_ready;
    logic [1:0][31:0]  m2_data;

    int n_asserts = 0;
    int n_fails   = 0;

    instruction_mem_arbiter #(
        .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut1 (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (c1_valid),
        .consumer_read_address (c1_addr),
        .consumer_read_ready   (c1_ready),
        .consumer_read_data    (c1_data),
        .mem_read_valid        (m1_valid),
        .mem_read_address      (m1_addr),
        .mem_read_ready        (m1_ready),
        .mem_read_data         (m1_data)
    );

    instruction_mem_arbiter #(
        .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut2 (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (c2_valid),
        .consumer_read_address (c2_addr),
        .consumer_read_ready   (c2_ready),
        .consumer_read_data    (c2_data),
        .mem_read_valid        (m2_valid),
        .mem_read_address      (m2_addr),
        .mem_read_ready        (m2_ready),
        .mem_read_data         (m2_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch on the 1-channel instance where consumer k should win the grant.
    task automatic serve_one(input int k, input bit rearm);
        tick();
        check($sformatf("fair_mvalid_c%0d", k), m1_valid, 1);
        check($sformatf("fair_maddr_c%0d", k), m1_addr, 32'h100 + 4 * k);
        m1_ready   = 1'b1;
        m1_data[0] = 32'hA000_0000 + k;
        tick();
        m1_ready = 1'b0;
        check($sformatf("fair_ready_c%0d", k), c1_ready, 128'(1) << k);
        check($sformatf("fair_data_c%0d", k), c1_data[k], 32'hA000_0000 + k);
        c1_valid[k] = 1'b0;
        tick();
        check($sformatf("fair_release_c%0d", k), c1_ready, 0);
        if (rearm)
            c1_valid[k] = 1'b1;
    endtask

    initial begin
        // Reset held with random inputs
        reset    = 1'b0;
        c1_valid = 4'($urandom);
        c2_valid = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
            c1_addr[k] = $urandom;
            c2_addr[k] = $urandom;
        end
        m1_ready   = 1'($urandom);
        m1_data[0] = $urandom;
        m2_ready   = 2'($urandom);
        m2_data[0] = $urandom;
        m2_data[1] = $urandom;
        repeat (3) tick();
        check("rst_c1_ready", c1_ready, 0);
        check("rst_c1_data",  c1_data,  0);
        check("rst_m1_valid", m1_valid, 0);
        check("rst_m1_addr",  m1_addr,  0);
        check("rst_c2_ready", c2_ready, 0);
        check("rst_c2_data",  c2_data,  0);
        check("rst_m2_valid", m2_valid, 0);
        check("rst_m2_addr",  m2_addr,  0);

        c1_valid = '0; c1_addr = '0; m1_ready = '0; m1_data = '0;
        c2_valid = '0; c2_addr = '0; m2_ready = '0; m2_data = '0;
        reset = 1'b1;
        tick();
        check("post_rst_m1_valid", m1_valid, 0);
        check("post_rst_m2_valid", m2_valid, 0);

        // Two channels, consumers 1 and 3 together
        c2_addr[1] = 32'h10;
        c2_addr[3] = 32'h30;
        c2_valid   = 4'b1010;
        tick();
        check("dual_m_valid", m2_valid, 2'b11);
        check("dual_addr_ch0", m2_addr[0], 32'h10);
        check("dual_addr_ch1", m2_addr[1], 32'h30);
        tick();
        check("dual_wait_ready", c2_ready, 0);
        check("dual_wait_mvalid", m2_valid, 2'b11);
        m2_ready   = 2'b11;
        m2_data[0] = 32'h1111_1111;
        m2_data[1] = 32'h3333_3333;
        tick();
        m2_ready = 2'b00;
        check("dual_ready", c2_ready, 4'b1010);
        check("dual_data1", c2_data[1], 32'h1111_1111);
        check("dual_data3", c2_data[3], 32'h3333_3333);
        check("dual_mvalid_drop", m2_valid, 2'b00);
        c2_valid = 4'b0000;
        tick();
        check("dual_release_ready", c2_ready, 0);
        check("dual_release_data", c2_data, 0);
        c2_addr[0] = 32'h20;
        c2_valid   = 4'b0001;
        tick();
        check("single_on_dual_mvalid", m2_valid, 2'b01);
        check("single_on_dual_addr", m2_addr[0], 32'h20);
        m2_ready   = 2'b11;
        m2_data[0] = 32'h00C0_FFEE;
        m2_data[1] = 32'h0000_0BAD;
        tick();
        m2_ready = 2'b00;
        check("single_on_dual_ready", c2_ready, 4'b0001);
        check("single_on_dual_data", c2_data, 128'h00C0_FFEE);
        c2_valid = 4'b0000;
        tick();
        check("single_on_dual_release", c2_ready, 0);

        // Single fetch: consumer 2, address 0x40, memory answers 2 cycles later
        c1_addr[2] = 32'h40;
        c1_valid   = 4'b0100;
        tick();
        check("fetch_mvalid", m1_valid, 1);
        check("fetch_maddr", m1_addr, 32'h40);
        check("fetch_ready_early", c1_ready, 0);
        tick();
        check("fetch_wait_mvalid", m1_valid, 1);
        check("fetch_wait_ready", c1_ready, 0);
        m1_ready   = 1'b1;
        m1_data[0] = 32'hDEAD_BEEF;
        tick();
        m1_ready = 1'b0;
        check("fetch_ready", c1_ready, 4'b0100);
        check("fetch_data", c1_data[2], 32'hDEAD_BEEF);
        check("fetch_mvalid_drop", m1_valid, 0);
        c1_valid = 4'b0000;
        tick();
        check("fetch_release_ready", c1_ready, 0);
        check("fetch_release_data", c1_data, 0);

        // Fairness from rr_ptr 0 with all four consumers requesting
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++)
            c1_addr[k] = 32'h100 + 4 * k;
        c1_valid = 4'b1111;
        serve_one(0, 1'b1);
        serve_one(1, 1'b1);
        serve_one(2, 1'b1);
        serve_one(3, 1'b1);
        serve_one(0, 1'b0);
        c1_valid = 4'b0000;
        tick();
        check("idle_no_requests", m1_valid, 0);

        // Consumer 1 keeps valid high after ready; stray memory ready is ignored
        c1_addr[1] = 32'h200;
        c1_valid   = 4'b0010;
        tick();
        check("hold_mvalid", m1_valid, 1);
        check("hold_maddr", m1_addr, 32'h200);
        m1_ready   = 1'b1;
        m1_data[0] = 32'h5555_AAAA;
        tick();
        m1_ready = 1'b0;
        check("hold_ready_0", c1_ready, 4'b0010);
        check("hold_data_0", c1_data[1], 32'h5555_AAAA);
        for (int i = 1; i < 5; i++) begin
            if (i == 2) begin
                m1_ready   = 1'b1;
                m1_data[0] = 32'hBAD0_BAD0;
            end
            tick();
            m1_ready = 1'b0;
            check($sformatf("hold_ready_%0d", i), c1_ready, 4'b0010);
            check($sformatf("hold_data_%0d", i), c1_data[1], 32'h5555_AAAA);
            check($sformatf("hold_mvalid_%0d", i), m1_valid, 0);
        end
        c1_valid = 4'b0000;
        tick();
        check("hold_release_ready", c1_ready, 0);
        check("hold_release_data", c1_data, 0);
        c1_addr[3] = 32'h300;
        c1_valid   = 4'b1000;
        tick();
        check("regrant_mvalid", m1_valid, 1);
        check("regrant_maddr", m1_addr, 32'h300);

        // Asynchronous reset while the channel waits on memory
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_mvalid", m1_valid, 0);
        check("async_rst_maddr", m1_addr, 0);
        check("async_rst_ready", c1_ready, 0);
        c1_valid   = 4'b0000;
        m1_ready   = 1'b1;
        m1_data[0] = 32'hBADB_AD00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        m1_ready = 1'b0;
        check("late_ready_ignored", c1_ready, 0);
        check("late_data_ignored", c1_data, 0);
        check("late_mvalid", m1_valid, 0);
        c1_addr[2] = 32'h440;
        c1_valid   = 4'b0100;
        tick();
        check("after_rst_mvalid", m1_valid, 1);
        check("after_rst_maddr", m1_addr, 32'h440);
        m1_ready   = 1'b1;
        m1_data[0] = 32'h1234_5678;
        tick();
        m1_ready = 1'b0;
        check("after_rst_ready", c1_ready, 4'b0100);
        check("after_rst_data", c1_data[2], 32'h1234_5678);
        c1_valid = 4'b0000;
        tick();
        check("after_rst_release", c1_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
